// File: rtl/bcd_countdown_ctrl.sv
// Two-digit BCD countdown timer controller: prescaler, load/start/pause/done
// sequencing and the tens/ones digit registers feeding the display path.
module bcd_countdown_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int PCNT_W   = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PCNT_W-1:0] PRESC_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [PCNT_W-1:0] PRESC_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PRESC_ZERO = {PCNT_W{1'b0}};

    // Out-of-range preset digits saturate at 9 so the digits stay valid BCD.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        if (d > 4'd9) begin
            clamp_bcd = 4'd9;
        end else begin
            clamp_bcd = d;
        end
    endfunction

    state_t            state_r, state_next_s;
    logic [3:0]        tens_r, tens_next_s;
    logic [3:0]        ones_r, ones_next_s;
    logic [3:0]        lat_tens_r, lat_tens_next_s;
    logic [3:0]        lat_ones_r, lat_ones_next_s;
    logic [PCNT_W-1:0] presc_r, presc_next_s;
    logic              tick_r, tick_next_s;
    logic [3:0]        dec_tens_s, dec_ones_s;
    logic [3:0]        cap_tens_s, cap_ones_s;

    assign cap_tens_s = clamp_bcd(preset_tens);
    assign cap_ones_s = clamp_bcd(preset_ones);

    // State, digit, latched-preset, prescaler and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
            lat_tens_r <= 4'd0;
            lat_ones_r <= 4'd0;
            presc_r    <= PRESC_ZERO;
            tick_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tens_r     <= tens_next_s;
            ones_r     <= ones_next_s;
            lat_tens_r <= lat_tens_next_s;
            lat_ones_r <= lat_ones_next_s;
            presc_r    <= presc_next_s;
            tick_r     <= tick_next_s;
        end
    end

    // One-step BCD decrement that borrows from tens and saturates at 00.
    always_comb begin
        dec_tens_s = tens_r;
        dec_ones_s = ones_r;
        if (ones_r != 4'd0) begin
            dec_ones_s = ones_r - 4'd1;
        end else if (tens_r != 4'd0) begin
            dec_ones_s = 4'd9;
            dec_tens_s = tens_r - 4'd1;
        end else begin
            dec_ones_s = 4'd0;
            dec_tens_s = 4'd0;
        end
    end

    // Next-state and datapath update; load beats start beats pause.
    always_comb begin
        state_next_s    = state_r;
        tens_next_s     = tens_r;
        ones_next_s     = ones_r;
        lat_tens_next_s = lat_tens_r;
        lat_ones_next_s = lat_ones_r;
        presc_next_s    = presc_r;
        tick_next_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    tens_next_s     = cap_tens_s;
                    ones_next_s     = cap_ones_s;
                    lat_tens_next_s = cap_tens_s;
                    lat_ones_next_s = cap_ones_s;
                end else if (start) begin
                    presc_next_s = PRESC_ZERO;
                    if ((tens_r == 4'd0) && (ones_r == 4'd0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A simultaneous load or start masks pause even though both are ignored here.
                if (pause && !load && !start) begin
                    state_next_s = ST_PAUSE;
                end else if (presc_r == PRESC_LAST) begin
                    presc_next_s = PRESC_ZERO;
                    tick_next_s  = 1'b1;
                    tens_next_s  = dec_tens_s;
                    ones_next_s  = dec_ones_s;
                    if ((dec_tens_s == 4'd0) && (dec_ones_s == 4'd0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    presc_next_s = presc_r + PRESC_ONE;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    tens_next_s     = cap_tens_s;
                    ones_next_s     = cap_ones_s;
                    lat_tens_next_s = cap_tens_s;
                    lat_ones_next_s = cap_ones_s;
                    presc_next_s    = PRESC_ZERO;
                    state_next_s    = ST_IDLE;
                end else if (start || pause) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (load) begin
                    tens_next_s     = cap_tens_s;
                    ones_next_s     = cap_ones_s;
                    lat_tens_next_s = cap_tens_s;
                    lat_ones_next_s = cap_ones_s;
                    presc_next_s    = PRESC_ZERO;
                    state_next_s    = ST_IDLE;
                end else if (start) begin
                    tens_next_s  = lat_tens_r;
                    ones_next_s  = lat_ones_r;
                    presc_next_s = PRESC_ZERO;
                    if ((lat_tens_r == 4'd0) && (lat_ones_r == 4'd0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                presc_next_s = PRESC_ZERO;
            end
        endcase
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            ST_IDLE:  begin busy = 1'b0; done = 1'b0; end
            ST_RUN:   begin busy = 1'b1; done = 1'b0; end
            ST_PAUSE: begin busy = 1'b1; done = 1'b0; end
            ST_DONE:  begin busy = 1'b0; done = 1'b1; end
            default:  begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    assign tens  = tens_r;
    assign ones  = ones_r;
    assign tick  = tick_r;
    assign state = state_r;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with TICK_DIV=4; inputs change and
// outputs are sampled on the falling edge.
module tb_bcd_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_countdown_ctrl #(.TICK_DIV(4), .PCNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .start       (start),
        .pause       (pause),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .tens        (tens),
        .ones        (ones),
        .tick        (tick),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Present one set of pulses for exactly one rising edge; call at a falling edge.
    task automatic apply(input logic l, input logic s, input logic p,
                         input logic [3:0] pt, input logic [3:0] po);
        load = l; start = s; pause = p; preset_tens = pt; preset_ones = po;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        logic saw_tick;
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        preset_tens = 4'd0; preset_ones = 4'd0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_digits", {tens, ones}, 8'h00);
        check_eq("rst_state", {6'd0, state}, 8'd0);
        check_eq("rst_flags", {5'd0, tick, busy, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic countdown from 12
        apply(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        check_eq("load12", {tens, ones}, 8'h12);
        check_eq("load12_state", {6'd0, state}, 8'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check_eq("e0_state", {6'd0, state}, 8'd1);
        check_eq("e0_busy", {7'd0, busy}, 8'd1);
        cyc(3);
        check_eq("e3_digits", {tens, ones}, 8'h12);
        check_eq("e3_tick", {7'd0, tick}, 8'd0);
        cyc(1);
        check_eq("e4_digits", {tens, ones}, 8'h11);
        check_eq("e4_tick", {7'd0, tick}, 8'd1);
        cyc(1);
        check_eq("e5_tick", {7'd0, tick}, 8'd0);
        cyc(3);
        check_eq("e8_digits", {tens, ones}, 8'h10);
        cyc(4);
        check_eq("e12_wrap", {tens, ones}, 8'h09);
        cyc(35);
        check_eq("e47_digits", {tens, ones}, 8'h01);
        check_eq("e47_done", {7'd0, done}, 8'd0);
        cyc(1);
        check_eq("e48_digits", {tens, ones}, 8'h00);
        check_eq("e48_flags", {5'd0, tick, busy, done}, 8'b101);
        check_eq("e48_state", {6'd0, state}, 8'd3);
        cyc(1);
        check_eq("e49_tick", {7'd0, tick}, 8'd0);

        // Pause / resume keeps the prescaler phase
        apply(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
        check_eq("reload12_state", {6'd0, state}, 8'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        cyc(4);
        check_eq("p_first_tick", {tens, ones}, 8'h11);
        cyc(2);
        apply(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check_eq("p_state", {6'd0, state}, 8'd2);
        check_eq("p_busy", {7'd0, busy}, 8'd1);
        saw_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick) saw_tick = 1'b1;
        end
        check_eq("p_hold_digits", {tens, ones}, 8'h11);
        check_eq("p_hold_notick", {7'd0, saw_tick}, 8'd0);
        check_eq("p_hold_state", {6'd0, state}, 8'd2);
        apply(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check_eq("resume_state", {6'd0, state}, 8'd1);
        cyc(1);
        check_eq("resume_r1", {tens, ones}, 8'h11);
        cyc(1);
        check_eq("resume_r2", {tens, ones}, 8'h10);
        check_eq("resume_r2_tick", {7'd0, tick}, 8'd1);

        // Load ignored in RUN, honoured in PAUSE and IDLE (with clamp)
        apply(1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
        check_eq("run_load_digits", {tens, ones}, 8'h10);
        check_eq("run_load_state", {6'd0, state}, 8'd1);
        apply(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        apply(1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
        check_eq("pause_load_digits", {tens, ones}, 8'h33);
        check_eq("pause_load_state", {6'd0, state}, 8'd0);
        apply(1'b1, 1'b0, 1'b0, 4'hF, 4'hA);
        check_eq("clamp_digits", {tens, ones}, 8'h99);

        // Zero preset and load/start priority
        apply(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check_eq("zero_state", {6'd0, state}, 8'd3);
        check_eq("zero_flags", {5'd0, tick, busy, done}, 8'b001);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check_eq("zero_restart", {6'd0, state}, 8'd3);
        apply(1'b1, 1'b1, 1'b0, 4'd0, 4'd5);
        check_eq("prio_state", {6'd0, state}, 8'd0);
        check_eq("prio_digits", {tens, ones}, 8'h05);

        // Restart from DONE reloads the latched preset
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        cyc(19);
        check_eq("d05_e19", {tens, ones}, 8'h01);
        cyc(1);
        check_eq("d05_done", {6'd0, state}, 8'd3);
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check_eq("restart_digits", {tens, ones}, 8'h05);
        check_eq("restart_state", {6'd0, state}, 8'd1);
        cyc(4);
        check_eq("restart_e4", {tens, ones}, 8'h04);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check_eq("arst_digits", {tens, ones}, 8'h00);
        check_eq("arst_state", {6'd0, state}, 8'd0);
        check_eq("arst_flags", {5'd0, tick, busy, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check_eq("post_rst_done", {6'd0, state}, 8'd3);
        check_eq("post_rst_flag", {7'd0, done}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
